fetch_unit: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the RISC_TOY pipeline.
- Consumes the hazard unit's PCWrite/IMRead/FDWrite controls and the Jump/Branch/Taken redirect from the execute stage.
- Drives the synchronous instruction memory and presents PC, PC+4, instruction and valid to decode.
- Tracks fetch-slot validity so stalls and redirects never leak stale or wrong-path words into decode.

---
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RISC_TOY fetch stage and IF/ID pipeline register.
// Tracks fetch-slot validity so stalls and redirects never hand stale or wrong-path words to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             PCWrite,
    input  logic             IMRead,
    input  logic             FDWrite,
    input  logic             Jump,
    input  logic             Branch,
    input  logic             Taken,
    input  logic [31:0]      RedirectPC,
    output logic [31:0]      IADDR,
    output logic             IREQ,
    input  logic [31:0]      IDATA,
    output logic [31:0]      PC_D,
    output logic [31:0]      PCPlus4_D,
    output logic [31:0]      INSTR_D,
    output logic             Valid_D,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    logic [31:0]      r_pc_f;
    logic             r_fvalid;
    logic [31:0]      r_pc_d;
    logic [31:0]      r_instr_d;
    logic             r_valid_d;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic        w_redirect;
    logic        w_fetch;
    logic [31:0] w_target;
    logic [31:0] w_pc_f_plus4;

    assign w_redirect   = Jump | (Branch & Taken);
    assign w_target     = RedirectPC & 32'hFFFF_FFFC;
    assign w_pc_f_plus4 = r_pc_f + 32'd4;
    // PCWrite=0 with IMRead=1 is an illegal hazard combination; it is treated as no fetch.
    assign w_fetch      = IMRead & PCWrite & ~w_redirect;

    assign IREQ      = IMRead & ~w_redirect;
    assign IADDR     = r_fvalid ? w_pc_f_plus4 : r_pc_f;
    assign PC_D      = r_pc_d;
    assign PCPlus4_D = r_pc_d + 32'd4;
    assign INSTR_D   = r_instr_d;
    assign Valid_D   = r_valid_d;
    assign StallCnt  = r_stall_cnt;
    assign FlushCnt  = r_flush_cnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pc_f   <= RESET_PC;
            r_fvalid <= 1'b0;
        end else if (w_redirect) begin
            r_pc_f   <= w_target;
            r_fvalid <= 1'b0;
        end else if (w_fetch) begin
            if (r_fvalid) begin
                r_pc_f <= w_pc_f_plus4;
            end
            r_fvalid <= 1'b1;
        end
    end

    // A redirect squashes decode even while the hazard unit holds IF/ID.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pc_d    <= 32'h0000_0000;
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (w_redirect) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (FDWrite) begin
            r_pc_d    <= r_pc_f;
            r_instr_d <= r_fvalid ? IDATA : NOP_INSTR;
            r_valid_d <= r_fvalid;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!FDWrite && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_redirect && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    a_pcwrite_imread : assert property (@(posedge CLK) disable iff (!RSTn) !(IMRead && !PCWrite));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: IM model returns the address as data, and a scoreboard
// queue holds the PCs expected to enter decode in program order.
module tb_fetch_unit;

    logic        CLK;
    logic        RSTn;
    logic        PCWrite, IMRead, FDWrite, Jump, Branch, Taken;
    logic [31:0] RedirectPC;
    logic [31:0] IADDR;
    logic        IREQ;
    logic [31:0] IDATA;
    logic [31:0] PC_D, PCPlus4_D, INSTR_D;
    logic        Valid_D;
    logic [15:0] StallCnt, FlushCnt;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] r_im_data;
    logic        mon_fd, mon_rd, mon_rs;
    logic [31:0] mon_exp;

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000), .CNT_W(16)) dut (
        .CLK(CLK), .RSTn(RSTn), .PCWrite(PCWrite), .IMRead(IMRead), .FDWrite(FDWrite),
        .Jump(Jump), .Branch(Branch), .Taken(Taken), .RedirectPC(RedirectPC),
        .IADDR(IADDR), .IREQ(IREQ), .IDATA(IDATA), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
        .INSTR_D(INSTR_D), .Valid_D(Valid_D), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (IREQ) r_im_data <= IADDR;
    end
    assign IDATA = r_im_data;

    // Scoreboard: every new valid entry into decode must match the next expected PC.
    always @(posedge CLK) begin
        mon_fd = FDWrite;
        mon_rd = Jump | (Branch & Taken);
        mon_rs = RSTn;
        #1;
        if (mon_rs && RSTn && mon_fd && !mon_rd && Valid_D === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: PC_D=%h entered decode, want none", PC_D);
            end else begin
                mon_exp = exp_q.pop_front();
                if (PC_D !== mon_exp || INSTR_D !== mon_exp) begin
                    n_err++;
                    $display("FAIL sb_order: PC_D=%h INSTR_D=%h, want %h", PC_D, INSTR_D, mon_exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time expired, want completion");
        $fatal(1, "watchdog");
    end

    task automatic push_seq(input logic [31:0] start);
        logic [31:0] a;
        a = start;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    task automatic set_flow(input logic en);
        PCWrite = en;
        IMRead  = en;
        FDWrite = en;
    endtask

    task automatic test_reset;
        RSTn = 1'b1; set_flow(1'b1);
        Jump = 1'b0; Branch = 1'b0; Taken = 1'b0; RedirectPC = 32'h0;
        #1 RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        push_seq(32'h0);
        RSTn = 1'b1;
        #1;
        n_cmp++; if (IADDR !== 32'h0) begin n_err++; $display("FAIL rst_iaddr: got %h want %h", IADDR, 32'h0); end
        n_cmp++; if (IREQ !== 1'b1) begin n_err++; $display("FAIL rst_ireq: got %b want 1", IREQ); end
        n_cmp++; if (Valid_D !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", Valid_D); end
        n_cmp++; if (PC_D !== 32'h0 || INSTR_D !== 32'h0) begin n_err++; $display("FAIL rst_d: got %h/%h want 0/0", PC_D, INSTR_D); end
        n_cmp++; if (StallCnt !== 16'h0 || FlushCnt !== 16'h0) begin n_err++; $display("FAIL rst_cnt: got %h/%h want 0/0", StallCnt, FlushCnt); end
    endtask

    task automatic test_startup;
        @(negedge CLK);
        n_cmp++; if (IADDR !== 32'h4) begin n_err++; $display("FAIL start_e1_iaddr: got %h want %h", IADDR, 32'h4); end
        n_cmp++; if (Valid_D !== 1'b0) begin n_err++; $display("FAIL start_e1_valid: got %b want 0", Valid_D); end
        @(negedge CLK);
        n_cmp++; if (Valid_D !== 1'b1 || PC_D !== 32'h0 || INSTR_D !== 32'h0) begin
            n_err++; $display("FAIL start_e2: got v=%b pc=%h ins=%h want v=1 pc=0 ins=0", Valid_D, PC_D, INSTR_D); end
        @(negedge CLK);
        n_cmp++; if (PC_D !== 32'h4 || PCPlus4_D !== 32'h8) begin
            n_err++; $display("FAIL start_e3: got pc=%h p4=%h want 4/8", PC_D, PCPlus4_D); end
    endtask

    task automatic test_stall;
        repeat (2) @(negedge CLK);
        set_flow(1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_cmp++; if (PC_D !== 32'hC || INSTR_D !== 32'hC || Valid_D !== 1'b1) begin
                n_err++; $display("FAIL stall_hold_d: cyc %0d got %h/%h/%b want c/c/1", i, PC_D, INSTR_D, Valid_D); end
            n_cmp++; if (IADDR !== 32'h14) begin n_err++; $display("FAIL stall_hold_iaddr: cyc %0d got %h want %h", i, IADDR, 32'h14); end
        end
        n_cmp++; if (StallCnt !== 16'd3) begin n_err++; $display("FAIL stall_cnt: got %0d want 3", StallCnt); end
        set_flow(1'b1);
        @(negedge CLK);
        n_cmp++; if (PC_D !== 32'h10 || INSTR_D !== 32'h10) begin n_err++; $display("FAIL stall_resume: got %h/%h want 10/10", PC_D, INSTR_D); end
    endtask

    task automatic test_jump;
        repeat (3) @(negedge CLK);
        n_cmp++; if (IADDR !== 32'h24) begin n_err++; $display("FAIL jump_pre_iaddr: got %h want %h", IADDR, 32'h24); end
        Jump = 1'b1; RedirectPC = 32'h100;
        push_seq(32'h100);
        #1;
        n_cmp++; if (IREQ !== 1'b0) begin n_err++; $display("FAIL jump_ireq: got %b want 0", IREQ); end
        @(negedge CLK);
        n_cmp++; if (Valid_D !== 1'b0 || INSTR_D !== 32'h0) begin n_err++; $display("FAIL jump_squash: got %b/%h want 0/0", Valid_D, INSTR_D); end
        n_cmp++; if (IADDR !== 32'h100) begin n_err++; $display("FAIL jump_iaddr: got %h want %h", IADDR, 32'h100); end
        n_cmp++; if (FlushCnt !== 16'd1) begin n_err++; $display("FAIL jump_flushcnt: got %0d want 1", FlushCnt); end
        Jump = 1'b0;
        @(negedge CLK);
        n_cmp++; if (Valid_D !== 1'b0) begin n_err++; $display("FAIL jump_bubble: got %b want 0", Valid_D); end
        @(negedge CLK);
        n_cmp++; if (PC_D !== 32'h100 || Valid_D !== 1'b1) begin n_err++; $display("FAIL jump_target: got %h/%b want 100/1", PC_D, Valid_D); end
    endtask

    task automatic test_branch;
        Branch = 1'b1; Taken = 1'b0;
        #1;
        n_cmp++; if (IREQ !== 1'b1) begin n_err++; $display("FAIL br_nt_ireq: got %b want 1", IREQ); end
        @(negedge CLK);
        n_cmp++; if (PC_D !== 32'h104 || Valid_D !== 1'b1) begin n_err++; $display("FAIL br_nt_seq: got %h/%b want 104/1", PC_D, Valid_D); end
        @(negedge CLK);
        set_flow(1'b0); Taken = 1'b1; RedirectPC = 32'h203;
        push_seq(32'h200);
        @(negedge CLK);
        n_cmp++; if (Valid_D !== 1'b0) begin n_err++; $display("FAIL br_tk_squash: got %b want 0", Valid_D); end
        n_cmp++; if (IADDR !== 32'h200) begin n_err++; $display("FAIL br_tk_iaddr: got %h want %h", IADDR, 32'h200); end
        n_cmp++; if (FlushCnt !== 16'd2 || StallCnt !== 16'd4) begin n_err++; $display("FAIL br_tk_cnt: got %0d/%0d want 2/4", FlushCnt, StallCnt); end
        Branch = 1'b0; Taken = 1'b0; set_flow(1'b1);
        repeat (2) @(negedge CLK);
        n_cmp++; if (PC_D !== 32'h200 || Valid_D !== 1'b1) begin n_err++; $display("FAIL br_tk_target: got %h/%b want 200/1", PC_D, Valid_D); end
    endtask

    task automatic test_wrap;
        Jump = 1'b1; RedirectPC = 32'hFFFF_FFF8;
        push_seq(32'hFFFF_FFF8);
        @(negedge CLK);
        Jump = 1'b0;
        @(negedge CLK);
        n_cmp++; if (IADDR !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_iaddr_hi: got %h want %h", IADDR, 32'hFFFF_FFFC); end
        @(negedge CLK);
        n_cmp++; if (IADDR !== 32'h0) begin n_err++; $display("FAIL wrap_iaddr: got %h want %h", IADDR, 32'h0); end
        n_cmp++; if (PC_D !== 32'hFFFF_FFF8 || PCPlus4_D !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_d1: got %h/%h want fffffff8/fffffffc", PC_D, PCPlus4_D); end
        @(negedge CLK);
        n_cmp++; if (PC_D !== 32'hFFFF_FFFC || PCPlus4_D !== 32'h0) begin
            n_err++; $display("FAIL wrap_p4: got %h/%h want fffffffc/0", PC_D, PCPlus4_D); end
        @(negedge CLK);
        n_cmp++; if (PC_D !== 32'h0 || FlushCnt !== 16'd3) begin n_err++; $display("FAIL wrap_d3: got %h/%0d want 0/3", PC_D, FlushCnt); end
    endtask

    task automatic test_reset_mid;
        Jump = 1'b1; RedirectPC = 32'h300;
        exp_q.delete();
        @(negedge CLK);
        Jump = 1'b0;
        RSTn = 1'b0;
        #1;
        n_cmp++; if (IADDR !== 32'h0) begin n_err++; $display("FAIL mid_rst_iaddr: got %h want %h", IADDR, 32'h0); end
        n_cmp++; if (Valid_D !== 1'b0 || PC_D !== 32'h0) begin n_err++; $display("FAIL mid_rst_d: got %b/%h want 0/0", Valid_D, PC_D); end
        n_cmp++; if (StallCnt !== 16'h0 || FlushCnt !== 16'h0) begin n_err++; $display("FAIL mid_rst_cnt: got %h/%h want 0/0", StallCnt, FlushCnt); end
        push_seq(32'h0);
        @(negedge CLK);
        RSTn = 1'b1;
        #1;
        n_cmp++; if (IADDR !== 32'h0 || IREQ !== 1'b1) begin n_err++; $display("FAIL mid_rel: got %h/%b want 0/1", IADDR, IREQ); end
        repeat (2) @(negedge CLK);
        n_cmp++; if (PC_D !== 32'h0 || Valid_D !== 1'b1) begin n_err++; $display("FAIL mid_restart: got %h/%b want 0/1", PC_D, Valid_D); end
        @(negedge CLK);
        n_cmp++; if (PC_D !== 32'h4) begin n_err++; $display("FAIL mid_seq: got %h want %h", PC_D, 32'h4); end
    endtask

    task automatic test_saturate;
        set_flow(1'b0);
        repeat (65534) @(negedge CLK);
        n_cmp++; if (StallCnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_pre: got %h want %h", StallCnt, 16'hFFFE); end
        @(negedge CLK);
        n_cmp++; if (StallCnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hit: got %h want %h", StallCnt, 16'hFFFF); end
        repeat (6) @(negedge CLK);
        n_cmp++; if (StallCnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want %h", StallCnt, 16'hFFFF); end
        n_cmp++; if (Valid_D !== 1'b1 || PC_D !== 32'h4) begin n_err++; $display("FAIL sat_d_hold: got %b/%h want 1/4", Valid_D, PC_D); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_jump();
        test_branch();
        test_wrap();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
